// File: rtl/gray_seq_decoder.sv
// Receive side of the Gray counter link: decodes each sample to binary with one
// cycle of latency and checks that it is a hold, +1 or wrap of the previous sample.
module gray_seq_decoder #(
   parameter int WIDTH = 3,
   parameter int CNT_W = 4
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             In_Valid,
   input  logic [WIDTH-1:0] In_Gray,
   input  logic             Clear,
   output logic             Out_Valid,
   output logic [WIDTH-1:0] Out_Bin,
   output logic             Wrap,
   output logic [CNT_W-1:0] Wrap_Count,
   output logic             Step_Err,
   output logic             Err_Sticky,
   output logic [1:0]       State
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_TRACK = 2'b01,
      S_LOST  = 2'b10
   } state_t;

   localparam logic [WIDTH-1:0] MAX_VAL = '1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state,    w_state_nxt;
   logic [WIDTH-1:0] r_prev,     w_prev_nxt;
   logic [WIDTH-1:0] r_bin,      w_bin_nxt;
   logic             r_valid,    w_valid_nxt;
   logic             r_wrap,     w_wrap_nxt;
   logic [CNT_W-1:0] r_wrap_cnt, w_wrap_cnt_nxt;
   logic             r_step_err, w_step_err_nxt;
   logic             r_err_stk,  w_err_stk_nxt;

   logic [WIDTH-1:0] w_bin;
   logic [WIDTH-1:0] w_prev_inc;
   logic             w_is_hold;
   logic             w_is_step;
   logic             w_is_wrap;

   // Each binary bit is the XOR of all Gray bits at or above it.
   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_dec
         assign w_bin[gi] = ^In_Gray[WIDTH-1:gi];
      end
   endgenerate

   assign w_prev_inc = r_prev + WIDTH'(1);
   assign w_is_hold  = (w_bin == r_prev);
   assign w_is_step  = (r_prev != MAX_VAL) && (w_bin == w_prev_inc);
   assign w_is_wrap  = (r_prev == MAX_VAL) && (w_bin == '0);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state    <= S_IDLE;
         r_prev     <= '0;
         r_bin      <= '0;
         r_valid    <= 1'b0;
         r_wrap     <= 1'b0;
         r_wrap_cnt <= '0;
         r_step_err <= 1'b0;
         r_err_stk  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_prev     <= w_prev_nxt;
         r_bin      <= w_bin_nxt;
         r_valid    <= w_valid_nxt;
         r_wrap     <= w_wrap_nxt;
         r_wrap_cnt <= w_wrap_cnt_nxt;
         r_step_err <= w_step_err_nxt;
         r_err_stk  <= w_err_stk_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_prev_nxt     = r_prev;
      w_bin_nxt      = r_bin;
      w_valid_nxt    = 1'b0;
      w_wrap_nxt     = r_wrap;
      w_wrap_cnt_nxt = r_wrap_cnt;
      w_step_err_nxt = 1'b0;
      w_err_stk_nxt  = r_err_stk;

      if (Clear) begin
         // Clear drops any sample on the same edge; Out_Bin keeps its last value.
         w_state_nxt    = S_IDLE;
         w_prev_nxt     = '0;
         w_wrap_nxt     = 1'b0;
         w_wrap_cnt_nxt = '0;
         w_err_stk_nxt  = 1'b0;
      end else if (In_Valid) begin
         w_valid_nxt = 1'b1;
         w_bin_nxt   = w_bin;
         w_prev_nxt  = w_bin;
         case (r_state)
            S_TRACK: begin
               if (w_is_wrap) begin
                  w_wrap_nxt = 1'b1;
                  if (r_wrap_cnt != CNT_MAX)
                     w_wrap_cnt_nxt = r_wrap_cnt + CNT_W'(1);
               end else if (!(w_is_hold || w_is_step)) begin
                  w_step_err_nxt = 1'b1;
                  w_err_stk_nxt  = 1'b1;
                  w_state_nxt    = S_LOST;
               end
            end
            // IDLE, LOST and the unused encoding all take the sample as reference.
            default: w_state_nxt = S_TRACK;
         endcase
      end
   end

   assign Out_Valid  = r_valid;
   assign Out_Bin    = r_bin;
   assign Wrap       = r_wrap;
   assign Wrap_Count = r_wrap_cnt;
   assign Step_Err   = r_step_err;
   assign Err_Sticky = r_err_stk;
   assign State      = r_state;

endmodule

// File: tb/tb_gray_seq_decoder.sv
// Bench for gray_seq_decoder: directed sequences then random traffic, every
// output compared each cycle against a behavioural model of the link rules.
module tb_gray_seq_decoder;

   localparam int WIDTH = 3;
   localparam int CNT_W = 2;
   localparam int MAXV  = (1 << WIDTH) - 1;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             Clk = 1'b0;
   logic             Reset = 1'b0;
   logic             In_Valid = 1'b0;
   logic [WIDTH-1:0] In_Gray = '0;
   logic             Clear = 1'b0;
   logic             Out_Valid;
   logic [WIDTH-1:0] Out_Bin;
   logic             Wrap;
   logic [CNT_W-1:0] Wrap_Count;
   logic             Step_Err;
   logic             Err_Sticky;
   logic [1:0]       State;

   gray_seq_decoder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .Clk(Clk), .Reset(Reset), .In_Valid(In_Valid), .In_Gray(In_Gray),
      .Clear(Clear), .Out_Valid(Out_Valid), .Out_Bin(Out_Bin), .Wrap(Wrap),
      .Wrap_Count(Wrap_Count), .Step_Err(Step_Err), .Err_Sticky(Err_Sticky),
      .State(State)
   );

   always #5 Clk = ~Clk;

   int n_chk  = 0;
   int n_pass = 0;

   // model: state 0 idle, 1 track, 2 lost
   int m_state, m_prev, m_bin, m_valid, m_wrap, m_cnt, m_err, m_stk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
   endtask

   function automatic int to_gray(input int b);
      return b ^ (b >> 1);
   endfunction

   // Inverse by search: the binary value whose Gray code matches.
   function automatic int from_gray(input int g);
      for (int k = 0; k <= MAXV; k++)
         if (to_gray(k) == g) return k;
      return -1;
   endfunction

   task automatic model_reset();
      m_state = 0; m_prev = 0; m_bin = 0; m_valid = 0;
      m_wrap = 0; m_cnt = 0; m_err = 0; m_stk = 0;
   endtask

   task automatic model_edge(input bit v, input int g, input bit c);
      int b;
      m_valid = 0;
      m_err   = 0;
      if (c) begin
         m_state = 0; m_wrap = 0; m_cnt = 0; m_stk = 0;
      end else if (v) begin
         b = from_gray(g);
         m_valid = 1;
         m_bin   = b;
         if (m_state == 1) begin
            if (b == m_prev || (m_prev != MAXV && b == m_prev + 1)) ;
            else if (m_prev == MAXV && b == 0) begin
               m_wrap = 1;
               m_cnt  = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
            end else begin
               m_err = 1; m_stk = 1; m_state = 2;
            end
         end else m_state = 1;
         m_prev = b;
      end
   endtask

   task automatic check_all();
      chk("out_valid",  Out_Valid,  m_valid);
      chk("out_bin",    Out_Bin,    m_bin);
      chk("wrap",       Wrap,       m_wrap);
      chk("wrap_count", Wrap_Count, m_cnt);
      chk("step_err",   Step_Err,   m_err);
      chk("err_sticky", Err_Sticky, m_stk);
      chk("state",      State,      m_state);
   endtask

   task automatic step(input bit v, input int g, input bit c);
      @(negedge Clk);
      In_Valid = v;
      In_Gray  = g[WIDTH-1:0];
      Clear    = c;
      @(posedge Clk);
      model_edge(v, g, c);
      #1;
      check_all();
   endtask

   task automatic send_bin(input int b);
      step(1'b1, to_gray(b), 1'b0);
   endtask

   // Pull reset low between edges and confirm outputs drop before the next edge.
   task automatic mid_reset();
      @(posedge Clk);
      #3 Reset = 1'b0;
      #1;
      model_reset();
      chk("rst_async", {Out_Valid, Out_Bin, Wrap, Wrap_Count, Step_Err, Err_Sticky, State}, 0);
      @(posedge Clk);
      #3 Reset = 1'b1;
      #1 check_all();
   endtask

   initial begin
      int r, b;
      model_reset();
      #2 check_all();
      #20 Reset = 1'b1;

      // full count 0..7, then four wraps saturating the counter
      for (int lap = 0; lap < 5; lap++)
         for (int k = 0; k <= MAXV; k++) send_bin(k);
      chk("wrap_sat", Wrap_Count, CMAX);

      // 1 -> 3 is illegal; then 4 re-anchors, 5 is a legal step
      send_bin(0); send_bin(1); send_bin(3);
      chk("err_lost", State, 2'b10);
      send_bin(4); send_bin(5);
      chk("relock", State, 2'b01);

      // clear with a sample present, flags set
      step(1'b1, 3'b011, 1'b1);
      chk("clr_bin_held", Out_Bin, 5);

      // hold twice then idle
      step(1'b1, 3'b011, 1'b0);
      step(1'b1, 3'b011, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b0, 0, 1'b0);

      // async reset during streaming, then 110 taken as reference
      send_bin(3);
      mid_reset();
      step(1'b1, 3'b110, 1'b0);
      chk("post_rst_bin", Out_Bin, 4);

      // random traffic biased toward legal successors
      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(99);
         if (r < 45)      b = (m_prev + 1) % (MAXV + 1);
         else if (r < 65) b = m_prev;
         else             b = $urandom_range(MAXV);
         if ($urandom_range(99) == 0) mid_reset();
         step($urandom_range(99) < 75, to_gray(b), $urandom_range(99) < 3);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
